lag_eq_arbiter: RTL

// - Shares one lag-equality checker among NREQ bit-stream requesters. The checker

---
 rtl/lag_eq_pkg.sv | 14 +
 rtl/lag_eq_core.sv | 57 +++++
 rtl/lag_eq_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lag_eq_pkg.sv
// Shared types and default sizing for the lag-equality arbiter slice.
package lag_eq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int LAG_DEF   = 2;
    localparam int BURST_DEF = 8;

endpackage

// File: rtl/lag_eq_core.sv
// LAG-deep bit history with a registered XNOR compare of the incoming bit
// against the bit accepted LAG shifts earlier.
module lag_eq_core
    import lag_eq_pkg::*;
#(
    parameter int LAG = LAG_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic shift,
    input  logic bit_in,
    input  logic cmp_en,
    output logic match,
    output logic match_valid
);

    logic [LAG-1:0] hist_q, hist_d;
    logic           match_q, match_d;
    logic           match_valid_q, match_valid_d;

    // Next history and compare result; the compare uses the history as it
    // stands before this cycle's shift.
    always_comb begin
        hist_d        = hist_q;
        match_d       = match_q;
        match_valid_d = cmp_en;
        if (clr) begin
            hist_d = '0;
        end else if (shift) begin
            hist_d[0] = bit_in;
            for (int i = 1; i < LAG; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
        if (cmp_en) begin
            match_d = ~(bit_in ^ hist_q[LAG-1]);
        end
    end

    // History and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q        <= '0;
            match_q       <= 1'b0;
            match_valid_q <= 1'b0;
        end else begin
            hist_q        <= hist_d;
            match_q       <= match_d;
            match_valid_q <= match_valid_d;
        end
    end

    assign match       = match_q;
    assign match_valid = match_valid_q;

endmodule

// File: rtl/lag_eq_arbiter.sv
// Round-robin arbiter that time-shares one lag-equality checker among NREQ
// serial-bit requesters, with a per-session bit limit and history cleared
// between owners.
module lag_eq_arbiter
    import lag_eq_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LAG   = LAG_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          bit_valid,
    input  logic [NREQ-1:0]          bit_in,
    input  logic [NREQ-1:0]          bit_last,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     match_valid,
    output logic                     match,
    output logic [$clog2(NREQ)-1:0]  match_owner
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   match_owner_q, match_owner_d;

    logic            pick_found;
    logic [OW-1:0]   pick_idx;
    logic            accept;
    logic [CW-1:0]   cnt_inc;
    logic            session_end;
    logic            core_clr;
    logic            core_shift;
    logic            core_cmp_en;

    // Rotating priority search: first set req at or after ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req[(int'(ptr_q) + i) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = OW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    // Session FSM: accept qualification, bit counting, end detection and
    // hand-off to the next requester.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        busy_d        = busy_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        match_owner_d = match_owner_q;
        core_clr      = 1'b0;
        core_shift    = 1'b0;
        core_cmp_en   = 1'b0;

        accept      = busy_q & gnt_q[owner_q] & bit_valid[owner_q];
        cnt_inc     = cnt_q + 1'b1;
        // Abort (req dropped) ends the session even without an accept; an
        // accept that is the last bit or hits the cap ends it too.
        session_end = (accept & (bit_last[owner_q] | (cnt_inc == CW'(BURST))))
                      | ~req[owner_q];

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (accept) begin
                    core_shift = 1'b1;
                    cnt_d      = cnt_inc;
                end
                if (session_end) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = RELEASE;
                end else if (accept && (cnt_inc == CW'(LAG))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    core_shift    = 1'b1;
                    core_cmp_en   = 1'b1;
                    cnt_d         = cnt_inc;
                    match_owner_d = owner_q;
                end
                if (session_end) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                core_clr = 1'b1;
                cnt_d    = '0;
                // Releasing owner becomes lowest priority next time round.
                ptr_d    = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and owner registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            busy_q        <= 1'b0;
            owner_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            match_owner_q <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            match_owner_q <= match_owner_d;
        end
    end

    lag_eq_core #(
        .LAG (LAG)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (core_clr),
        .shift       (core_shift),
        .bit_in      (bit_in[owner_q]),
        .cmp_en      (core_cmp_en),
        .match       (match),
        .match_valid (match_valid)
    );

    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign match_owner = match_owner_q;

endmodule
